// File: rtl/load_queue_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | load_queue_if : allocate / ROB-permission / issue bundle of the     |
// |                 age-ordered load queue                              |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
interface load_queue_if #(
  parameter int DEPTH    = 4,
  parameter int XLEN     = 32,
  parameter int ROB_IX_W = 3
);
  localparam int c_CNT_W = $clog2(DEPTH + 1);

  logic                       flush_in;
  logic                       valid_input_in;
  logic [XLEN-1:0]            dest_in;
  logic [ROB_IX_W-1:0]        rob_ix_in;
  logic [2:0]                 funct3_in;
  logic                       ready_out;
  logic [DEPTH-1:0]           can_load_in;
  logic [DEPTH*XLEN-1:0]      lb_dest_out;
  logic [DEPTH*ROB_IX_W-1:0]  lb_rob_ix_out;
  logic [DEPTH-1:0]           lb_occupied_out;
  logic [c_CNT_W-1:0]         count_out;
  logic [XLEN-1:0]            dest_out;
  logic [ROB_IX_W-1:0]        rob_ix_out;
  logic [2:0]                 funct3_out;
  logic                       valid_out;
  logic                       read_in;

  modport master (
    output flush_in, valid_input_in, dest_in, rob_ix_in, funct3_in,
           can_load_in, read_in,
    input  ready_out, lb_dest_out, lb_rob_ix_out, lb_occupied_out,
           count_out, dest_out, rob_ix_out, funct3_out, valid_out
  );

  modport slave (
    input  flush_in, valid_input_in, dest_in, rob_ix_in, funct3_in,
           can_load_in, read_in,
    output ready_out, lb_dest_out, lb_rob_ix_out, lb_occupied_out,
           count_out, dest_out, rob_ix_out, funct3_out, valid_out
  );
endinterface
`default_nettype wire

// File: rtl/load_queue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | load_queue : parametrised age-ordered load buffer feeding a         |
// |              registered valid/read issue stage                      |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module load_queue #(
  parameter int DEPTH    = 4,
  parameter int XLEN     = 32,
  parameter int ROB_IX_W = 3
) (
  input  wire logic   clk_in,
  input  wire logic   rst_n_in,
  load_queue_if.slave lq
);
  localparam int                 c_IX_W  = $clog2(DEPTH);
  localparam int                 c_CNT_W = $clog2(DEPTH + 1);
  localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

  logic [DEPTH-1:0]                r_occupied;
  logic [DEPTH-1:0][XLEN-1:0]      r_dest;
  logic [DEPTH-1:0][ROB_IX_W-1:0]  r_rob_ix;
  logic [DEPTH-1:0][2:0]           r_funct3;
  // r_older[i][j] is set when slot j was allocated before slot i
  logic [DEPTH-1:0][DEPTH-1:0]     r_older;
  logic [c_CNT_W-1:0]              r_count;
  logic [XLEN-1:0]                 r_dest_out;
  logic [ROB_IX_W-1:0]             r_rob_ix_out;
  logic [2:0]                      r_funct3_out;
  logic                            r_valid_out;

  logic [DEPTH-1:0]                w_eligible;
  logic [DEPTH-1:0]                w_occ_next;
  logic                            w_alloc;
  logic                            w_fire;
  logic [c_IX_W-1:0]               w_alloc_ix;
  logic [c_IX_W-1:0]               w_issue_ix;

  always_comb begin
    w_eligible = r_occupied & lq.can_load_in;
    w_alloc    = lq.valid_input_in && !(&r_occupied);
    w_alloc_ix = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_occupied[i]) w_alloc_ix = c_IX_W'(i);
    end
    // The oldest eligible slot is the only eligible one with no eligible elder
    w_issue_ix = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_eligible[i] && ((w_eligible & r_older[i]) == '0)) w_issue_ix = c_IX_W'(i);
    end
    w_fire     = (!r_valid_out || lq.read_in) && (|w_eligible);
    w_occ_next = r_occupied;
    if (w_alloc) w_occ_next[w_alloc_ix] = 1'b1;
    if (w_fire)  w_occ_next[w_issue_ix] = 1'b0;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_occupied   <= '0;
      r_dest       <= '0;
      r_rob_ix     <= '0;
      r_funct3     <= '0;
      r_older      <= '0;
      r_count      <= '0;
      r_dest_out   <= '0;
      r_rob_ix_out <= '0;
      r_funct3_out <= '0;
      r_valid_out  <= 1'b0;
    end else if (lq.flush_in) begin
      r_occupied  <= '0;
      r_count     <= '0;
      r_valid_out <= 1'b0;
    end else begin
      r_occupied <= w_occ_next;

      if (w_alloc) begin
        r_dest[w_alloc_ix]   <= lq.dest_in;
        r_rob_ix[w_alloc_ix] <= lq.rob_ix_in;
        r_funct3[w_alloc_ix] <= lq.funct3_in;
        // New entry is younger than every current occupant; stale bits of a reused slot are wiped
        for (int i = 0; i < DEPTH; i++) begin
          r_older[i][w_alloc_ix] <= 1'b0;
        end
        r_older[w_alloc_ix] <= r_occupied;
      end

      if (w_alloc && !w_fire) begin
        r_count <= r_count + c_ONE;
      end else if (w_fire && !w_alloc) begin
        r_count <= r_count - c_ONE;
      end

      if (w_fire) begin
        r_dest_out   <= r_dest[w_issue_ix];
        r_rob_ix_out <= r_rob_ix[w_issue_ix];
        r_funct3_out <= r_funct3[w_issue_ix];
        r_valid_out  <= 1'b1;
      end else if (lq.read_in) begin
        r_valid_out  <= 1'b0;
      end
    end
  end

  assign lq.ready_out       = ~(&r_occupied);
  assign lq.lb_dest_out     = r_dest;
  assign lq.lb_rob_ix_out   = r_rob_ix;
  assign lq.lb_occupied_out = r_occupied;
  assign lq.count_out       = r_count;
  assign lq.dest_out        = r_dest_out;
  assign lq.rob_ix_out      = r_rob_ix_out;
  assign lq.funct3_out      = r_funct3_out;
  assign lq.valid_out       = r_valid_out;

endmodule
`default_nettype wire

// File: tb/tb_load_queue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_load_queue : directed scenarios plus random traffic against an  |
// |                 age-list reference model of the load queue         |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_load_queue;
  localparam int DEPTH    = 4;
  localparam int XLEN     = 32;
  localparam int ROB_IX_W = 3;
  localparam int CNT_W    = $clog2(DEPTH + 1);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  load_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN), .ROB_IX_W(ROB_IX_W)) lq ();

  load_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .ROB_IX_W(ROB_IX_W)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .lq       (lq.slave)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: slots plus a list of slot numbers kept in allocation order
  bit                  m_occ  [DEPTH];
  logic [XLEN-1:0]     m_dest [DEPTH];
  logic [ROB_IX_W-1:0] m_rob  [DEPTH];
  logic [2:0]          m_f3   [DEPTH];
  int                  m_age  [$];
  bit                  m_vout;
  logic [XLEN-1:0]     m_dout;
  logic [ROB_IX_W-1:0] m_rout;
  logic [2:0]          m_fout;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_occ[i] = 0; m_dest[i] = '0; m_rob[i] = '0; m_f3[i] = '0;
    end
    m_age.delete();
    m_vout = 0; m_dout = '0; m_rout = '0; m_fout = '0;
  endtask

  task automatic model_step();
    int  pick;
    int  slot;
    int  free_ix;
    bit  full;
    if (!rst_n) begin model_reset(); return; end
    if (lq.flush_in) begin
      for (int i = 0; i < DEPTH; i++) m_occ[i] = 0;
      m_age.delete();
      m_vout = 0;
      return;
    end
    full    = (m_age.size() == DEPTH);
    free_ix = -1;
    for (int i = DEPTH - 1; i >= 0; i--) if (!m_occ[i]) free_ix = i;
    pick = -1;
    if (!m_vout || lq.read_in) begin
      for (int k = 0; k < m_age.size(); k++) begin
        if (lq.can_load_in[m_age[k]]) begin pick = k; break; end
      end
    end
    if (pick >= 0) begin
      slot   = m_age[pick];
      m_dout = m_dest[slot]; m_rout = m_rob[slot]; m_fout = m_f3[slot];
      m_vout = 1;
      m_occ[slot] = 0;
      m_age.delete(pick);
    end else if (m_vout && lq.read_in) begin
      m_vout = 0;
    end
    if (lq.valid_input_in && !full) begin
      m_occ[free_ix]  = 1;
      m_dest[free_ix] = lq.dest_in;
      m_rob[free_ix]  = lq.rob_ix_in;
      m_f3[free_ix]   = lq.funct3_in;
      m_age.push_back(free_ix);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic vin, input logic [XLEN-1:0] d, input logic [ROB_IX_W-1:0] r,
                       input logic [2:0] f, input logic [DEPTH-1:0] cl, input logic rd, input logic fl);
    lq.valid_input_in = vin; lq.dest_in = d; lq.rob_ix_in = r; lq.funct3_in = f;
    lq.can_load_in = cl; lq.read_in = rd; lq.flush_in = fl;
  endtask

  task automatic test_reset();
    drive(0, '0, '0, '0, '0, 0, 0);
    rst_n = 1'b0;
    tick(); tick();
    total++; if (lq.lb_occupied_out !== 4'b0000) begin bad++; $display("FAIL rst_occ got=%b exp=0000", lq.lb_occupied_out); end
    total++; if (lq.count_out !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", lq.count_out); end
    total++; if (lq.ready_out !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", lq.ready_out); end
    total++; if (lq.valid_out !== 1'b0 || lq.dest_out !== '0 || lq.rob_ix_out !== '0 || lq.funct3_out !== '0) begin
      bad++; $display("FAIL rst_out got v=%b d=%h r=%0d f=%0d exp all zero", lq.valid_out, lq.dest_out, lq.rob_ix_out, lq.funct3_out);
    end
    rst_n = 1'b1;
    tick();
    total++; if (lq.valid_out !== 1'b0 || lq.lb_occupied_out !== 4'b0000) begin
      bad++; $display("FAIL rst_release got v=%b occ=%b exp v=0 occ=0000", lq.valid_out, lq.lb_occupied_out);
    end
  endtask

  task automatic test_alloc_issue();
    logic [XLEN-1:0] exp_d [3];
    exp_d = '{32'h100, 32'h104, 32'h108};
    for (int k = 0; k < 3; k++) begin
      drive(1, exp_d[k], ROB_IX_W'(k + 1), 3'(k), '0, 0, 0);
      tick();
    end
    drive(0, '0, '0, '0, '0, 0, 0);
    tick();
    total++; if (lq.lb_occupied_out !== 4'b0111) begin bad++; $display("FAIL alloc_occ got=%b exp=0111", lq.lb_occupied_out); end
    total++; if (lq.count_out !== 3'd3) begin bad++; $display("FAIL alloc_count got=%0d exp=3", lq.count_out); end
    total++; if (lq.valid_out !== 1'b0) begin bad++; $display("FAIL alloc_novalid got=%b exp=0", lq.valid_out); end
    total++; if (lq.lb_dest_out[1*XLEN +: XLEN] !== 32'h104 || lq.lb_rob_ix_out[1*ROB_IX_W +: ROB_IX_W] !== 3'd2) begin
      bad++; $display("FAIL alloc_slot1 got d=%h r=%0d exp d=104 r=2", lq.lb_dest_out[1*XLEN +: XLEN], lq.lb_rob_ix_out[1*ROB_IX_W +: ROB_IX_W]);
    end
    drive(0, '0, '0, '0, 4'hF, 1, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (lq.valid_out !== 1'b1 || lq.dest_out !== exp_d[k] || lq.rob_ix_out !== ROB_IX_W'(k + 1) || lq.funct3_out !== 3'(k)) begin
        bad++; $display("FAIL issue_order k=%0d got v=%b d=%h r=%0d f=%0d exp v=1 d=%h r=%0d f=%0d",
                        k, lq.valid_out, lq.dest_out, lq.rob_ix_out, lq.funct3_out, exp_d[k], k + 1, k);
      end
      total++; if (lq.count_out !== CNT_W'(2 - k)) begin bad++; $display("FAIL issue_count k=%0d got=%0d exp=%0d", k, lq.count_out, 2 - k); end
    end
    tick();
    total++; if (lq.valid_out !== 1'b0) begin bad++; $display("FAIL issue_drop got=%b exp=0", lq.valid_out); end
  endtask

  task automatic test_full_drop();
    logic [XLEN-1:0] exp_d [4];
    for (int k = 0; k < 4; k++) begin
      drive(1, 32'h300 + 32'(4 * k), ROB_IX_W'(k + 4), 3'd2, '0, 0, 0);
      tick();
    end
    total++; if (lq.ready_out !== 1'b0 || lq.lb_occupied_out !== 4'hF) begin
      bad++; $display("FAIL full_ready got rdy=%b occ=%b exp rdy=0 occ=1111", lq.ready_out, lq.lb_occupied_out);
    end
    drive(1, 32'h200, 3'd0, 3'd0, '0, 0, 0);
    tick();
    total++; if (lq.count_out !== 3'd4 || lq.lb_dest_out[1*XLEN +: XLEN] !== 32'h304) begin
      bad++; $display("FAIL full_drop got cnt=%0d slot1=%h exp cnt=4 slot1=304", lq.count_out, lq.lb_dest_out[1*XLEN +: XLEN]);
    end
    drive(0, '0, '0, '0, 4'b0010, 1, 0);
    tick();
    total++; if (lq.dest_out !== 32'h304 || lq.lb_occupied_out !== 4'b1101) begin
      bad++; $display("FAIL free_slot1 got d=%h occ=%b exp d=304 occ=1101", lq.dest_out, lq.lb_occupied_out);
    end
    drive(1, 32'h200, 3'd0, 3'd0, 4'b0000, 1, 0);
    tick();
    total++; if (lq.lb_dest_out[1*XLEN +: XLEN] !== 32'h200 || lq.lb_occupied_out !== 4'hF || lq.valid_out !== 1'b0) begin
      bad++; $display("FAIL reuse_slot1 got slot1=%h occ=%b v=%b exp slot1=200 occ=1111 v=0",
                      lq.lb_dest_out[1*XLEN +: XLEN], lq.lb_occupied_out, lq.valid_out);
    end
    exp_d = '{32'h300, 32'h308, 32'h30C, 32'h200};
    drive(0, '0, '0, '0, 4'hF, 1, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      total++; if (lq.valid_out !== 1'b1 || lq.dest_out !== exp_d[k]) begin
        bad++; $display("FAIL reuse_order k=%0d got v=%b d=%h exp d=%h", k, lq.valid_out, lq.dest_out, exp_d[k]);
      end
    end
    tick();
  endtask

  task automatic test_hold();
    for (int k = 0; k < 3; k++) begin
      drive(1, 32'h400 + 32'(4 * k), ROB_IX_W'(k), 3'd4, '0, 0, 0);
      tick();
    end
    drive(0, '0, '0, '0, 4'b0100, 0, 0);
    tick();
    drive(0, '0, '0, '0, 4'hF, 0, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      total++; if (lq.valid_out !== 1'b1 || lq.dest_out !== 32'h408 || lq.rob_ix_out !== 3'd2 || lq.count_out !== 3'd2) begin
        bad++; $display("FAIL hold k=%0d got v=%b d=%h r=%0d cnt=%0d exp v=1 d=408 r=2 cnt=2",
                        k, lq.valid_out, lq.dest_out, lq.rob_ix_out, lq.count_out);
      end
    end
    drive(0, '0, '0, '0, 4'hF, 1, 0);
    tick();
    total++; if (lq.valid_out !== 1'b1 || lq.dest_out !== 32'h400) begin
      bad++; $display("FAIL hold_accept got v=%b d=%h exp v=1 d=400", lq.valid_out, lq.dest_out);
    end
    tick();
    tick();
    total++; if (lq.valid_out !== 1'b0 || lq.count_out !== 3'd0) begin
      bad++; $display("FAIL hold_drain got v=%b cnt=%0d exp v=0 cnt=0", lq.valid_out, lq.count_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [XLEN-1:0] exp_d [3];
    for (int k = 0; k < 3; k++) begin
      drive(1, 32'h500 + 32'(4 * k), ROB_IX_W'(k), 3'd1, '0, 0, 0);
      tick();
    end
    drive(1, 32'h50C, 3'd3, 3'd5, 4'b0001, 1, 0);
    tick();
    total++; if (lq.count_out !== 3'd3 || lq.lb_occupied_out !== 4'b1110 || lq.dest_out !== 32'h500) begin
      bad++; $display("FAIL simul got cnt=%0d occ=%b d=%h exp cnt=3 occ=1110 d=500", lq.count_out, lq.lb_occupied_out, lq.dest_out);
    end
    exp_d = '{32'h504, 32'h508, 32'h50C};
    drive(0, '0, '0, '0, 4'hF, 1, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (lq.valid_out !== 1'b1 || lq.dest_out !== exp_d[k]) begin
        bad++; $display("FAIL simul_order k=%0d got v=%b d=%h exp d=%h", k, lq.valid_out, lq.dest_out, exp_d[k]);
      end
    end
    total++; if (lq.funct3_out !== 3'd5) begin bad++; $display("FAIL simul_f3 got=%0d exp=5", lq.funct3_out); end
    tick();
  endtask

  task automatic test_flush();
    for (int k = 0; k < 4; k++) begin
      drive(1, 32'h600 + 32'(4 * k), ROB_IX_W'(k), 3'd0, '0, 0, 0);
      tick();
    end
    drive(0, '0, '0, '0, 4'b0001, 0, 0);
    tick();
    drive(1, 32'h700, 3'd7, 3'd7, 4'hF, 1, 1);
    tick();
    total++; if (lq.lb_occupied_out !== 4'b0000 || lq.valid_out !== 1'b0 || lq.count_out !== 3'd0 || lq.ready_out !== 1'b1) begin
      bad++; $display("FAIL flush got occ=%b v=%b cnt=%0d rdy=%b exp occ=0000 v=0 cnt=0 rdy=1",
                      lq.lb_occupied_out, lq.valid_out, lq.count_out, lq.ready_out);
    end
    drive(0, '0, '0, '0, 4'hF, 1, 0);
    tick();
    total++; if (lq.valid_out !== 1'b0 || lq.lb_occupied_out !== 4'b0000) begin
      bad++; $display("FAIL flush_after got v=%b occ=%b exp v=0 occ=0000", lq.valid_out, lq.lb_occupied_out);
    end
  endtask

  task automatic test_async_reset();
    drive(1, 32'h800, 3'd1, 3'd2, '0, 0, 0); tick();
    drive(1, 32'h804, 3'd2, 3'd2, '0, 0, 0); tick();
    drive(0, '0, '0, '0, 4'hF, 1, 0);
    tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    total++; if (lq.valid_out !== 1'b0 || lq.dest_out !== '0 || lq.lb_occupied_out !== 4'b0000 || lq.count_out !== 3'd0) begin
      bad++; $display("FAIL async_rst got v=%b d=%h occ=%b cnt=%0d exp all zero", lq.valid_out, lq.dest_out, lq.lb_occupied_out, lq.count_out);
    end
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (lq.valid_out !== 1'b0) begin bad++; $display("FAIL async_post k=%0d got v=%b exp v=0", k, lq.valid_out); end
    end
  endtask

  task automatic test_random();
    logic [DEPTH-1:0] eocc;
    for (int c = 0; c < 600; c++) begin
      lq.flush_in       = ($urandom_range(0, 39) == 0);
      lq.valid_input_in = ($urandom_range(0, 99) < 55);
      lq.dest_in        = $urandom;
      lq.rob_ix_in      = ROB_IX_W'($urandom);
      lq.funct3_in      = 3'($urandom);
      lq.can_load_in    = DEPTH'($urandom);
      lq.read_in        = ($urandom_range(0, 99) < 65);
      tick();
      for (int i = 0; i < DEPTH; i++) eocc[i] = m_occ[i];
      total++; if (lq.lb_occupied_out !== eocc) begin bad++; $display("FAIL rnd_occ cyc=%0d got=%b exp=%b", c, lq.lb_occupied_out, eocc); end
      total++; if (lq.count_out !== CNT_W'(m_age.size())) begin bad++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", c, lq.count_out, m_age.size()); end
      total++; if (lq.ready_out !== (m_age.size() < DEPTH)) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b", c, lq.ready_out); end
      total++; if (lq.valid_out !== m_vout) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", c, lq.valid_out, m_vout); end
      if (m_vout) begin
        total++; if (lq.dest_out !== m_dout || lq.rob_ix_out !== m_rout || lq.funct3_out !== m_fout) begin
          bad++; $display("FAIL rnd_out cyc=%0d got d=%h r=%0d f=%0d exp d=%h r=%0d f=%0d",
                          c, lq.dest_out, lq.rob_ix_out, lq.funct3_out, m_dout, m_rout, m_fout);
        end
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (m_occ[i]) begin
          total++; if (lq.lb_dest_out[i*XLEN +: XLEN] !== m_dest[i] || lq.lb_rob_ix_out[i*ROB_IX_W +: ROB_IX_W] !== m_rob[i]) begin
            bad++; $display("FAIL rnd_slot cyc=%0d slot=%0d got d=%h r=%0d exp d=%h r=%0d", c, i,
                            lq.lb_dest_out[i*XLEN +: XLEN], lq.lb_rob_ix_out[i*ROB_IX_W +: ROB_IX_W], m_dest[i], m_rob[i]);
          end
        end
      end
    end
  endtask

  initial begin
    model_reset();
    drive(0, '0, '0, '0, '0, 0, 0);
    test_reset();
    test_alloc_issue();
    test_full_drop();
    test_hold();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
